approx_adder_pipe: RTL and testbench

- Parametrised, 2-stage pipelined lower-part-OR approximate adder with a per-transaction exact/approximate mode select.
- Valid/ready handshakes on both input and output.
- An exact reference sum is computed alongside every result and feeds a built-in error monitor: operation count, error count and maximum absolute error.
- Sits in the arithmetic datapath library as the successor to the fixed 32-bit, 16-bit-split approximate adder; used for accuracy/energy characterisation.

---
 rtl/approx_adder_pkg.sv | 33 +++
 rtl/approx_err_monitor.sv | 57 +++++
 rtl/approx_adder_pipe.sv | 124 ++++++++++++
 tb/tb_approx_adder_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_adder_pkg.sv
// Shared definitions for the lower-part-OR approximate adder: mode encoding,
// the approximate-sum reference function and an absolute-difference helper.
package approx_adder_pkg;

  localparam logic MODE_APPROX = 1'b0;
  localparam logic MODE_EXACT  = 1'b1;

  // Widest operand the helper functions support; callers zero-extend into these types.
  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] opnd_t;
  typedef logic [MAX_W:0]   sum_t;

  function automatic sum_t approx_sum(input opnd_t a, input opnd_t b,
                                      input int width, input int l);
    opnd_t wmask;
    opnd_t lmask;
    sum_t  lo;
    sum_t  hi;
    logic  cmsp;
    wmask = (width >= MAX_W) ? '1 : ((opnd_t'(1) << width) - opnd_t'(1));
    lmask = (opnd_t'(1) << l) - opnd_t'(1);
    cmsp  = a[l-1] & b[l-1];
    lo    = sum_t'((a | b) & lmask);
    hi    = sum_t'((a & wmask) >> l) + sum_t'((b & wmask) >> l) + sum_t'(cmsp);
    return (hi << l) | lo;
  endfunction

  function automatic sum_t abs_diff(input sum_t x, input sum_t y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/approx_err_monitor.sv
// Accuracy statistics: saturating operation/error counters and the running
// maximum error magnitude, with a synchronous clear that beats a same-cycle update.
module approx_err_monitor
  import approx_adder_pkg::*;
#(
  parameter int MAG_W = 33,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             hs_i,
  input  logic             err_i,
  input  logic [MAG_W-1:0] mag_i,
  output logic [CNT_W-1:0] op_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [MAG_W-1:0] max_abs_err_o
);

  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [MAG_W-1:0] max_q, max_d;

  always_comb begin
    op_cnt_d  = op_cnt_q;
    err_cnt_d = err_cnt_q;
    max_d     = max_q;
    if (clr_i) begin
      op_cnt_d  = '0;
      err_cnt_d = '0;
      max_d     = '0;
    end else if (hs_i) begin
      if (op_cnt_q != '1) op_cnt_d = op_cnt_q + CNT_W'(1);
      if (err_i) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (mag_i > max_q)   max_d     = mag_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_cnt_q  <= '0;
      err_cnt_q <= '0;
      max_q     <= '0;
    end else begin
      op_cnt_q  <= op_cnt_d;
      err_cnt_q <= err_cnt_d;
      max_q     <= max_d;
    end
  end

  assign op_cnt_o      = op_cnt_q;
  assign err_cnt_o     = err_cnt_q;
  assign max_abs_err_o = max_q;

endmodule

// File: rtl/approx_adder_pipe.sv
// Two-stage lower-part-OR approximate adder with per-transaction exact/approx
// mode, valid/ready on both sides and a built-in accuracy monitor.
module approx_adder_pipe
  import approx_adder_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int APPROX_BITS = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_err,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH:0]   max_abs_err
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_mode_q, s1_mode_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH:0]   s2_approx_q, s2_approx_d;
  logic [WIDTH:0]   s2_exact_q, s2_exact_d;
  logic             s2_mode_q, s2_mode_d;
  logic             s2_err_q, s2_err_d;

  logic             s1_adv, s2_adv, in_hs, out_hs;
  logic [WIDTH:0]   approx_w, exact_w, err_mag;

  assign s2_adv   = !s2_valid_q | out_ready;
  assign s1_adv   = !s1_valid_q | s2_adv;
  // Forced high while in reset so upstream never sees a stale stall.
  assign in_ready = s1_adv | !rst_n;
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = s2_valid_q & out_ready;

  assign approx_w = (WIDTH+1)'(approx_sum(opnd_t'(s1_a_q), opnd_t'(s1_b_q), WIDTH, APPROX_BITS));
  assign exact_w  = {1'b0, s1_a_q} + {1'b0, s1_b_q};

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_mode_d   = s1_mode_q;
    s2_valid_d  = s2_valid_q;
    s2_approx_d = s2_approx_q;
    s2_exact_d  = s2_exact_q;
    s2_mode_d   = s2_mode_q;
    s2_err_d    = s2_err_q;

    if (s1_adv) s1_valid_d = in_valid;
    if (in_hs) begin
      s1_a_d    = in_a;
      s1_b_d    = in_b;
      s1_mode_d = in_mode;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_approx_d = approx_w;
        s2_exact_d  = exact_w;
        s2_mode_d   = s1_mode_q;
        s2_err_d    = (s1_mode_q == MODE_APPROX) && (approx_w != exact_w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= MODE_APPROX;
      s2_valid_q  <= 1'b0;
      s2_approx_q <= '0;
      s2_exact_q  <= '0;
      s2_mode_q   <= MODE_APPROX;
      s2_err_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      s2_valid_q  <= s2_valid_d;
      s2_approx_q <= s2_approx_d;
      s2_exact_q  <= s2_exact_d;
      s2_mode_q   <= s2_mode_d;
      s2_err_q    <= s2_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sum   = (s2_mode_q == MODE_EXACT) ? s2_exact_q : s2_approx_q;
  assign out_err   = s2_err_q;
  assign err_mag   = (WIDTH+1)'(abs_diff(sum_t'(s2_approx_q), sum_t'(s2_exact_q)));

  approx_err_monitor #(
    .MAG_W (WIDTH + 1),
    .CNT_W (CNT_W)
  ) u_mon (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (clr_stats),
    .hs_i          (out_hs),
    .err_i         (s2_err_q),
    .mag_i         (err_mag),
    .op_cnt_o      (op_cnt),
    .err_cnt_o     (err_cnt),
    .max_abs_err_o (max_abs_err)
  );

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Directed bench for approx_adder_pipe: default-parameter instance plus a
// CNT_W=2 instance on the same stimulus to exercise counter saturation.
module tb_approx_adder_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_sum;
  logic        out_err;
  logic        clr_stats;
  logic [15:0] op_cnt;
  logic [15:0] err_cnt;
  logic [32:0] max_abs_err;

  logic        in_ready_s;
  logic        out_valid_s;
  logic [32:0] out_sum_s;
  logic        out_err_s;
  logic [1:0]  op_cnt_s;
  logic [1:0]  err_cnt_s;
  logic [32:0] max_abs_err_s;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] st_a [8];
  logic [31:0] st_b [8];
  logic [32:0] st_e [8];
  int          got, stall_left, stalls, cguard, dguard;
  logic [32:0] held;

  approx_adder_pipe #(.WIDTH(32), .APPROX_BITS(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
    .clr_stats(clr_stats), .op_cnt(op_cnt), .err_cnt(err_cnt),
    .max_abs_err(max_abs_err)
  );

  approx_adder_pipe #(.WIDTH(32), .APPROX_BITS(16), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_sum(out_sum_s), .out_err(out_err_s),
    .clr_stats(clr_stats), .op_cnt(op_cnt_s), .err_cnt(err_cnt_s),
    .max_abs_err(max_abs_err_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic stats(input string tag, input logic [15:0] op, input logic [15:0] er,
                       input logic [32:0] mx);
    chk({tag, "_op_cnt"}, 64'(op_cnt), 64'(op));
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(er));
    chk({tag, "_max_abs_err"}, 64'(max_abs_err), 64'(mx));
  endtask

  // Entered just after a falling edge with an empty pipeline and out_ready = 1.
  task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic mode, input logic [32:0] exp_sum, input logic exp_err);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(out_sum), 64'(exp_sum));
    chk({tag, "_err"}, 64'(out_err), 64'(exp_err));
    @(negedge clk);
    chk({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    clr_stats = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    stats("rst", 16'd0, 16'd0, 33'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Undershoot: lower-part carry dropped
    txn("v1", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 33'h0_0000_FFFF, 1'b1);
    stats("v1", 16'd1, 16'd1, 33'd1);

    // Overshoot through cmsp
    txn("v2", 32'h0000_8000, 32'h0000_8000, 1'b0, 33'h0_0001_8000, 1'b1);
    stats("v2", 16'd2, 16'd2, 33'h8000);

    txn("v3_exact", 32'h0000_8000, 32'h0000_8000, 1'b1, 33'h0_0001_0000, 1'b0);
    stats("v3", 16'd3, 16'd2, 33'h8000);

    txn("v4_carry", 32'hFFFF_0000, 32'h0001_0000, 1'b0, 33'h1_0000_0000, 1'b0);
    stats("v4", 16'd4, 16'd2, 33'h8000);

    // Smaller error must not lower the recorded maximum
    txn("v5", 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 33'h0_2143_5F7F, 1'b1);
    stats("v5", 16'd5, 16'd3, 33'h8000);
    chk("v5_sat_err", 64'(err_cnt_s), 64'd3);
    chk("v5_sat_op", 64'(op_cnt_s), 64'd3);

    txn("v6", 32'h0000_0003, 32'h0000_0001, 1'b0, 33'h0_0000_0003, 1'b1);
    txn("v7", 32'h0000_C000, 32'h0000_C000, 1'b0, 33'h0_0001_C000, 1'b1);
    stats("v7", 16'd7, 16'd5, 33'h8000);
    chk("v7_sat_err", 64'(err_cnt_s), 64'd3);
    chk("v7_sat_op", 64'(op_cnt_s), 64'd3);
    chk("v7_sat_max", 64'(max_abs_err_s), 64'h8000);

    // Streaming with a 3-cycle output stall after the third result
    for (int i = 0; i < 8; i++) begin
      st_a[i] = 32'h1000_0000 * (i + 1) + (i + 1);
      st_b[i] = 32'h0100_0000 * (i + 1) + ((i + 1) << 8);
      st_e[i] = {1'b0, st_a[i]} + {1'b0, st_b[i]};
    end
    got = 0; stall_left = 0; stalls = 0; cguard = 0; held = '0;
    fork
      begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
          in_valid = 1'b1;
          in_a     = st_a[i];
          in_b     = st_b[i];
          in_mode  = (i % 2 == 1);
          dguard   = 0;
          do begin
            @(negedge clk);
            dguard++;
          end while (!in_ready && dguard < 50);
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        while (got < 8 && cguard < 200) begin
          @(negedge clk);
          cguard++;
          if (out_valid && out_ready) begin
            chk("stream_sum", 64'(out_sum), 64'(st_e[got]));
            got++;
            if (got == 3) stall_left = 3;
          end else if (out_valid && !out_ready) begin
            stalls++;
            if (stalls > 1) begin
              chk("stall_hold_sum", 64'(out_sum), 64'(held));
              chk("stall_in_ready", 64'(in_ready), 64'd0);
            end
            held = out_sum;
          end
          @(posedge clk);
          #1;
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
      end
    join
    chk("stream_count", 64'(got), 64'd8);
    chk("stream_stalls", 64'(stalls), 64'd3);
    @(negedge clk);
    chk("stream_drained", 64'(out_valid), 64'd0);
    stats("stream", 16'd15, 16'd5, 33'h8000);
    chk("stream_sat_op", 64'(op_cnt_s), 64'd3);

    // clr_stats coincident with an output handshake
    in_valid = 1'b1;
    in_a     = 32'h0000_FFFF;
    in_b     = 32'h0000_0001;
    in_mode  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_out_valid", 64'(out_valid), 64'd1);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    chk("clr_consumed", 64'(out_valid), 64'd0);
    stats("clr", 16'd0, 16'd0, 33'd0);
    chk("clr_sat_op", 64'(op_cnt_s), 64'd0);
    chk("clr_sat_err", 64'(err_cnt_s), 64'd0);

    txn("after_clr", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 33'h0_0000_FFFF, 1'b1);
    stats("after_clr", 16'd1, 16'd1, 33'd1);

    // Reset with both stages occupied
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'h0000_0011;
    in_b      = 32'h0000_0022;
    in_mode   = 1'b1;
    @(negedge clk);
    in_a = 32'h0000_0033;
    in_b = 32'h0000_0044;
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_sum", 64'(out_sum), 64'd0);
    stats("mid_rst", 16'd0, 16'd0, 33'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_discard1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("rst_discard2", 64'(out_valid), 64'd0);
    txn("post_rst", 32'h0000_1000, 32'h0000_0234, 1'b1, 33'h0_0000_1234, 1'b0);
    stats("post_rst", 16'd1, 16'd0, 33'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
